deadband_event_detector: RTL and testbench
==========================================

# deadband_event_detector

Parametrised multi-channel deadband change detector. Each accepted sample is compared against its channel's stored baseline; an absolute difference greater than a programmable threshold updates the baseline and queues an event record in an output FIFO, drained through a valid/ready handshake. It sits between the input sampling stage and the downstream event consumer, and is the generalised successor of the fixed 4×8-bit, threshold-2 change flag.

## Interface

- `WIDTH`, 8: sample and baseline width in bits.
- `CHANNELS`, 4: number of channels (≥2); `CW = $clog2(CHANNELS)`.
- `FIFO_DEPTH`, 4: event FIFO depth, power of two, ≥2.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-high reset (asserted = 1).
- `in_valid`  in  1: sample offered.
- `in_ready`  out  1: sample can be accepted.
- `in_chan`  in  CW: channel index of the sample.
- `in_data`  in  WIDTH: sample value.
- `thresh`  in  WIDTH: deadband. An event fires only when the difference is strictly greater than this value.
- `ev_valid`  out  1: an event is at the FIFO head.
- `ev_ready`  in  1: the consumer takes the head event.
- `ev_chan`  out  CW: channel of the head event.
- `ev_data`  out  WIDTH: new baseline value of the head event.
- `ev_dir`  out  1: 1 = new value above the old baseline; 0 = below.
- `ev_total`  out  16: saturating count of events pushed since reset.

## Operation

- A sample is accepted on a cycle where `in_valid && in_ready`. `in_ready = !fifo_full`. No sample is ever dropped.
- Per-channel state:
  - `base[c]` (WIDTH bits), reset 0.
  - `primed[c]`, reset 0.
- Accepted sample on channel c:
  - `primed[c] == 0`: `base[c] <= in_data`, `primed[c] <= 1`, no event.
  - Otherwise compute `diff = (in_data >= base) ? in_data - base : base - in_data`, unsigned WIDTH bits, no wrap.
  - `diff > thresh`: `base[c] <= in_data`, push event `{c, in_data, in_data > base}`, increment `ev_total` (saturates at 16'hFFFF).
  - `diff <= thresh`, including equality: no state change, no event.
- `thresh` is sampled on the acceptance cycle. Changing it later does not alter decisions already made.
- `in_chan >= CHANNELS` (non-power-of-two CHANNELS): the sample is accepted and discarded, with no state change and no event.
- FIFO pop occurs on `ev_valid && ev_ready`. Push and pop in the same cycle are both legal when the FIFO is neither empty nor full; occupancy is then unchanged.
- Full: `in_ready` is low. A pop during a full cycle does not raise `in_ready` combinationally; `in_ready` rises the next cycle.
- Empty: `ev_valid` is low. Head outputs hold their last value and are don't-care.
- Head fields stay stable while `ev_valid && !ev_ready`.

## Timing

- Reset values: `in_ready = 1`, `ev_valid = 0`, `ev_chan = 0`, `ev_data = 0`, `ev_dir = 0`, `ev_total = 0`. All baselines are 0 and all primed bits are 0.
- Reset is asynchronous. Assertion mid-operation clears the FIFO, baselines, primed bits and the counter immediately. Events in flight are lost.
- Latency from acceptance to `ev_valid` (empty FIFO) is 1 cycle: the event is written on the accepting edge and visible after it.
- Baseline update and event push happen on the same edge.
- Back-to-back samples to the same channel: the second compares against the baseline written by the first, so there is no read-after-write hazard.
- Throughput is one sample per cycle while not full.

## Structure

- Package `deadband_pkg`:
  - `ev_dir_e` enum (DIR_DOWN = 0, DIR_UP = 1).
  - `ev_rec_t` packed struct {chan, data, dir}, parametrised through package-level widths or passed as a localparam within the block.
- Sub-module `event_fifo`:
  - Synchronous FIFO with flop storage, `FIFO_DEPTH` entries, `$clog2(FIFO_DEPTH)+1`-bit pointers for the full/empty distinction.
  - Exposes `full` and `empty`, plus head read.
- The top level holds the baseline array, primed bits, comparator, and the saturating counter.

## Test plan

- Reset, then ch0 sample 50, then ch0 sample 51: no events, `ev_total = 0`, `base[0] = 50`.
- `thresh = 2`, ch1 sequence 100, 102, 103:
  - 102: no event (diff 2).
  - 103: event {1, 103, UP} (diff 3), `ev_total = 1`.
- `thresh = 0`, ch2 sequence 200, 10: one event {2, 10, DOWN}. `diff = 190` is computed without wrap.
- Hold `ev_ready = 0` and generate 5 events with `FIFO_DEPTH = 4`:
  - `in_ready` drops after the 4th push.
  - 5th sample is stalled, not lost.
  - After one pop, the stalled sample is accepted and the FIFO order is preserved.
- Simultaneous push and pop at occupancy 2: occupancy stays 2, and the head advances to the older event.
- Assert `rst_n` mid-stream with 3 queued events: `ev_valid` goes to 0 immediately. The next ch0 sample after reset primes silently.

Source files
------------

// File: rtl/deadband_pkg.sv
// Shared types, counter width and helpers for the deadband event detector.
package deadband_pkg;

   // Direction of a detected change relative to the previous baseline.
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } ev_dir_e;

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Increment that sticks at the all-ones value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage : deadband_pkg

// File: rtl/event_fifo.sv
// Flop-based synchronous FIFO; extra pointer bit separates full from empty.
module event_fifo #(
   parameter int unsigned DW    = 11,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          full,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [DW-1:0] mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Head is the entry at the read pointer; stale contents when empty.
   assign head = mem[rd_ptr[AW-1:0]];

   // Pointer and storage update; reset wipes contents so head reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule : event_fifo

// File: rtl/deadband_event_detector.sv
// Multi-channel deadband change detector queuing event records in a FIFO.
module deadband_event_detector
   import deadband_pkg::*;
#(
   parameter  int unsigned WIDTH      = 8,
   parameter  int unsigned CHANNELS   = 4,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CW         = $clog2(CHANNELS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_chan,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] thresh,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [CW-1:0]    ev_chan,
   output logic [WIDTH-1:0] ev_data,
   output logic             ev_dir,
   output logic [CNT_W-1:0] ev_total
);

   // Event record carried through the FIFO.
   typedef struct packed {
      logic [CW-1:0]    chan;
      logic [WIDTH-1:0] data;
      ev_dir_e          dir;
   } ev_rec_t;

   localparam int unsigned REC_W = $bits(ev_rec_t);

   logic [WIDTH-1:0] base [CHANNELS];
   logic [CHANNELS-1:0] primed;

   logic             accept;
   logic             chan_ok;
   logic [WIDTH-1:0] cur_base;
   logic             cur_primed;
   logic [WIDTH-1:0] diff;
   logic             fire;
   logic             fifo_full;
   logic             fifo_empty;
   ev_rec_t          push_rec;
   ev_rec_t          head_rec;

   // Out-of-range indices only exist when CHANNELS is not a power of two.
   if (CHANNELS == 2**CW) begin : g_pow2
      assign chan_ok = 1'b1;
   end else begin : g_npow2
      assign chan_ok = ({1'b0, in_chan} < (CW+1)'(CHANNELS));
   end

   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready;

   // Compare the sample against its channel baseline without wraparound.
   always_comb begin
      cur_base   = '0;
      cur_primed = 1'b0;
      diff       = '0;
      fire       = 1'b0;
      push_rec   = '{chan: in_chan, data: in_data, dir: DIR_DOWN};
      if (chan_ok) begin
         cur_base   = base[in_chan];
         cur_primed = primed[in_chan];
      end
      diff = (in_data >= cur_base) ? (in_data - cur_base) : (cur_base - in_data);
      fire = accept && chan_ok && cur_primed && (diff > thresh);
      if (in_data > cur_base) begin
         push_rec.dir = DIR_UP;
      end
   end

   // Baselines, primed flags and the saturating event counter.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            base[c] <= '0;
         end
         primed   <= '0;
         ev_total <= '0;
      end else if (accept && chan_ok) begin
         if (!cur_primed) begin
            base[in_chan]   <= in_data;
            primed[in_chan] <= 1'b1;
         end else if (fire) begin
            base[in_chan] <= in_data;
            ev_total      <= sat_inc(ev_total);
         end
      end
   end

   logic [REC_W-1:0] head_bits;

   event_fifo #(
      .DW    (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst_n),
      .push      (fire),
      .push_data (push_rec),
      .pop       (ev_valid && ev_ready),
      .head      (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_rec = ev_rec_t'(head_bits);
   assign ev_valid = !fifo_empty;
   assign ev_chan  = head_rec.chan;
   assign ev_data  = head_rec.data;
   assign ev_dir   = (head_rec.dir == DIR_UP);

endmodule : deadband_event_detector

// File: tb/tb_deadband_event_detector.sv
// Directed self-checking bench for deadband_event_detector.
module tb_deadband_event_detector;

   localparam int unsigned W  = 8;
   localparam int unsigned CH = 4;
   localparam int unsigned CW = 2;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_chan;
   logic [W-1:0]  in_data;
   logic [W-1:0]  thresh;
   logic          ev_valid;
   logic          ev_ready;
   logic [CW-1:0] ev_chan;
   logic [W-1:0]  ev_data;
   logic          ev_dir;
   logic [15:0]   ev_total;

   int n_tests = 0;
   int n_fail  = 0;

   deadband_event_detector #(
      .WIDTH      (W),
      .CHANNELS   (CH),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_chan  (in_chan),
      .in_data  (in_data),
      .thresh   (thresh),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_chan  (ev_chan),
      .ev_data  (ev_data),
      .ev_dir   (ev_dir),
      .ev_total (ev_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Offer one sample (called at a falling edge); waits out back-pressure.
   task automatic send(input int c, input int d);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_chan  = CW'(c);
      in_data  = W'(d);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_stall_bound", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Check the head event then pop it with a one-cycle ready pulse.
   task automatic pop_check(input string tag, input int c, input int d, input int dir);
      check({tag, "_valid"}, 32'(ev_valid), 32'd1);
      check({tag, "_chan"},  32'(ev_chan),  32'(c));
      check({tag, "_data"},  32'(ev_data),  32'(d));
      check({tag, "_dir"},   32'(ev_dir),   32'(dir));
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_chan  = '0;
      in_data  = '0;
      thresh   = '0;
      ev_ready = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_ev_valid", 32'(ev_valid), 32'd0);
      check("rst_ev_chan",  32'(ev_chan),  32'd0);
      check("rst_ev_data",  32'(ev_data),  32'd0);
      check("rst_ev_dir",   32'(ev_dir),   32'd0);
      check("rst_ev_total", 32'(ev_total), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);

      // Priming and sub-threshold samples stay silent; baseline stays 50.
      thresh = 8'd2;
      send(0, 50);
      send(0, 51);
      check("prime_no_event", 32'(ev_valid), 32'd0);
      check("prime_total",    32'(ev_total), 32'd0);
      send(0, 53);
      check("base50_total", 32'(ev_total), 32'd1);
      pop_check("base50", 0, 53, 1);

      // Equality with threshold is not an event; one above is.
      send(1, 100);
      send(1, 102);
      check("eq_thresh_no_event", 32'(ev_valid), 32'd0);
      send(1, 103);
      check("above_thresh_total", 32'(ev_total), 32'd2);
      pop_check("ch1_up", 1, 103, 1);

      // Large downward step computed without wrap.
      thresh = 8'd0;
      send(2, 200);
      send(2, 10);
      check("down_total", 32'(ev_total), 32'd3);
      pop_check("ch2_down", 2, 10, 0);
      check("drained", 32'(ev_valid), 32'd0);

      // Fill the FIFO, stall the fifth sample, release with one pop.
      send(0, 60);
      send(1, 110);
      send(2, 20);
      check("ready_before_full", 32'(in_ready), 32'd1);
      send(0, 70);
      check("ready_at_full", 32'(in_ready), 32'd0);
      fork
         send(1, 120);
         begin
            repeat (3) @(negedge clk);
            check("stalled_ready", 32'(in_ready), 32'd0);
            check("stalled_total", 32'(ev_total), 32'd7);
            pop_check("full_pop0", 0, 60, 1);
         end
      join
      check("after_stall_total", 32'(ev_total), 32'd8);
      pop_check("order1", 1, 110, 1);
      pop_check("order2", 2, 20, 1);
      pop_check("order3", 0, 70, 1);
      pop_check("order4", 1, 120, 1);
      check("order_empty", 32'(ev_valid), 32'd0);

      // Simultaneous push and pop at occupancy 2.
      send(2, 30);
      send(2, 40);
      in_valid = 1'b1;
      in_chan  = 2'd0;
      in_data  = 8'd80;
      ev_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      ev_ready = 1'b0;
      check("pp_total", 32'(ev_total), 32'd11);
      pop_check("pp_head", 2, 40, 1);
      pop_check("pp_new", 0, 80, 1);
      check("pp_empty", 32'(ev_valid), 32'd0);

      // Asynchronous reset with three queued events.
      send(1, 130);
      send(1, 140);
      send(1, 150);
      check("queued_total", 32'(ev_total), 32'd14);
      #2 rst_n = 1'b1;
      #1;
      check("async_ev_valid", 32'(ev_valid), 32'd0);
      check("async_total",    32'(ev_total), 32'd0);
      check("async_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      send(0, 99);
      check("reprime_no_event", 32'(ev_valid), 32'd0);
      send(0, 100);
      check("reprime_total", 32'(ev_total), 32'd1);
      pop_check("reprime_ev", 0, 100, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_deadband_event_detector
